hidden_cpu_driver: RTL and testbench
====================================

Name: hidden_cpu_driver

Overview:
- Host-side counterpart of the 8-bit HiddenCPU pin interface.
- Drives the CPU's 8-bit input bus: bit0 is the CPU clock, bit1 is the CPU reset, bits 7:2 are the instruction (opcode, reg0 address, reg1 address).
- Consumes the CPU's 8-bit output bus as the program counter to fetch the next instruction from a local program RAM.
- Sits between a host/loader and the CPU core; provides program load, reset sequencing, stepping with a step limit, and result capture.

Parameters:
- ADDR_W, 4, program RAM address width; depth = 2**ADDR_W words of 6 bits.
- RST_PULSES, 2, number of CPU clock pulses issued with CPU reset held high.
- STEP_W, 16, width of the step limit and step counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- prog_we  input  1  program RAM write strobe
- prog_addr  input  ADDR_W  program RAM write address
- prog_data  input  6  instruction word: {opcode[1:0], reg0[1:0], reg1[1:0]}
- start  input  1  single-cycle pulse: begin a run
- stop  input  1  single-cycle pulse: abort a run
- max_steps  input  STEP_W  CPU clock pulses to execute after reset; 0 means unlimited
- cpu_in  output  8  to CPU input bus: {instr[5:0], cpu_rst, cpu_clk}
- cpu_out  input  8  from CPU output bus, treated as the PC
- busy  output  1  high from start until the run ends
- done  output  1  one-cycle pulse when a run ends
- step_count  output  STEP_W  CPU clock pulses executed in the current or last run
- last_out  output  8  cpu_out sampled after the most recent CPU rising edge

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; cpu_in = 8'h00; busy = 0; done = 0; step_count = 0; last_out = 0. Program RAM contents are not reset.
- Program RAM accepts writes only in IDLE or DONE. prog_we in any other state is ignored.
- FSM states: IDLE, RST_LO, RST_HI, SETUP, PULSE, DONE.
- Each CPU clock pulse spans 2 clk cycles: low phase (RST_LO/SETUP) then high phase (RST_HI/PULSE). cpu_clk = 1 only in high-phase states. cpu_in[7:2] is stable across both phases of a pulse.
- IDLE/DONE with start:
  - go to RST_LO; busy = 1; step_count cleared; internal reset-pulse count cleared.
  - start is ignored while busy.
- RST_LO -> RST_HI -> RST_LO, repeated until RST_PULSES high phases have completed; then go to SETUP.
  - cpu_rst = 1 throughout RST_LO/RST_HI.
  - cpu_in[7:2] = 0 during these states.
- SETUP:
  - cpu_rst = 0.
  - fetch_addr = cpu_out[ADDR_W-1:0], sampled this cycle.
  - cpu_in[7:2] = ram[fetch_addr], registered.
  - Go to PULSE.
- PULSE:
  - cpu_clk = 1; step_count increments by 1.
  - last_out is captured from cpu_out on the clk cycle after PULSE (the next SETUP entry), which gives one clk of settling.
- Termination, evaluated on leaving PULSE:
  - If max_steps != 0 and step_count (incremented) == max_steps, go to DONE.
  - Otherwise go to SETUP.
- step_count saturates at all-ones when max_steps = 0 and does not wrap.
- stop in any busy state:
  - goes to DONE on the next clk.
  - If stop arrives in PULSE, the pulse completes and is counted, and cpu_clk falls on the transition.
- DONE: done = 1 for exactly one cycle (on entry); busy = 0; cpu_in = 8'h00; state then holds DONE until start.
- Simultaneous start and stop while not busy: start wins. Simultaneous prog_we and start in IDLE: the write completes and the run starts.
- cpu_out upper bits [7:ADDR_W] are ignored for fetch. PC wrap-around is therefore modulo the RAM depth.
- rst_n asserted mid-run: immediate return to IDLE with cpu_in = 0. The CPU is not clocked again until the next start.

Decomposition:
- Shared package hidden_cpu_pkg:
  - opcode constants (2-bit).
  - instruction field offsets (opcode 5:4, reg0 3:2, reg1 1:0 within the 6-bit word).
  - cpu_in bit indices (CLK = 0, RST = 1, INSTR = 7:2).
  - FSM state enum.
- One sub-module: hidden_cpu_prog_ram, a 2**ADDR_W x 6 synchronous-write, asynchronous-read array with a write-enable gate input.

Test Plan:
- Load: write ram[0..3] = 6'h15, 6'h2A, 6'h3F, 6'h00 in IDLE; then start with max_steps = 0 and stop after 4 pulses -> the first post-reset SETUP with cpu_out = 0 drives cpu_in[7:2] = 6'h15.
- Reset sequence: RST_PULSES = 2, start -> exactly 2 cpu_clk high phases with cpu_in[1] = 1, each 1 clk wide; cpu_in[1] = 0 from the first SETUP onward.
- Step limit: max_steps = 5 with a stub CPU whose cpu_out increments per pulse -> 5 post-reset cpu_clk rising edges; step_count = 5; done pulses once; busy falls on the same cycle; last_out = 5.
- Fetch follows PC: stub cpu_out jumps 0 -> 9 -> 3 -> cpu_in[7:2] follows ram[0], ram[9], ram[3]. With ADDR_W = 4 and cpu_out = 8'h13, the fetch reads ram[3].
- Abort and write protection: prog_we during PULSE leaves RAM unchanged; stop in SETUP -> DONE next cycle with cpu_in = 0; stop in PULSE -> the pulse is counted and cpu_clk falls.
- Async reset: drop rst_n mid-PULSE -> cpu_in = 0, busy = 0, done = 0 immediately without waiting for clk; a later start reruns the full reset sequence.

Source files
------------

// File: rtl/hidden_cpu_pkg.sv
// hidden_cpu_pkg: opcodes, instruction field offsets, cpu_in bit indices and FSM states shared by the HiddenCPU host driver
package hidden_cpu_pkg;
    localparam logic [1:0] OP_0 = 2'd0;
    localparam logic [1:0] OP_1 = 2'd1;
    localparam logic [1:0] OP_2 = 2'd2;
    localparam logic [1:0] OP_3 = 2'd3;
    localparam int OPC_LSB = 4;
    localparam int R0_LSB = 2;
    localparam int R1_LSB = 0;
    localparam int CPU_CLK = 0;
    localparam int CPU_RST = 1;
    localparam int INSTR_LSB = 2;
    typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, SETUP, PULSE, DONE} state_t;
    function automatic logic [5:0] mk_instr(input logic [1:0] op, input logic [1:0] r0, input logic [1:0] r1);
        logic [5:0] w;
        w = '0;
        w[OPC_LSB +: 2] = op;
        w[R0_LSB +: 2] = r0;
        w[R1_LSB +: 2] = r1;
        return w;
    endfunction
endpackage

// File: rtl/hidden_cpu_driver_if.sv
// hidden_cpu_driver_if: host and CPU-pin bundle; master = host/loader + CPU, slave = driver (prog_*, start/stop/max_steps, cpu_in/cpu_out, busy/done/step_count/last_out)
interface hidden_cpu_driver_if #(
    parameter int ADDR_W = 4,
    parameter int STEP_W = 16
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [5:0]        prog_data;
    logic              start;
    logic              stop;
    logic [STEP_W-1:0] max_steps;
    logic [7:0]        cpu_in;
    logic [7:0]        cpu_out;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step_count;
    logic [7:0]        last_out;
    modport master (
        output prog_we, prog_addr, prog_data, start, stop, max_steps, cpu_out,
        input  cpu_in, busy, done, step_count, last_out
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, start, stop, max_steps, cpu_out,
        output cpu_in, busy, done, step_count, last_out
    );
endinterface

// File: rtl/hidden_cpu_prog_ram.sv
// hidden_cpu_prog_ram: 2**ADDR_W x 6 program store, sync write gated by en, async read (clk, we, en, waddr, wdata, raddr, rdata)
module hidden_cpu_prog_ram #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic              en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [5:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [5:0]        rdata
);
    logic [5:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we && en) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/hidden_cpu_driver.sv
// hidden_cpu_driver: sequences reset, fetch and clock pulses on the HiddenCPU pin bus (clk, rst_n async low; bus.slave carries host load/control/status and cpu_in/cpu_out)
module hidden_cpu_driver
    import hidden_cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int RST_PULSES = 2,
    parameter int STEP_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    hidden_cpu_driver_if.slave bus
);
    localparam int RC_W = $clog2(RST_PULSES + 1);
    state_t            state, state_n;
    logic [RC_W-1:0]   rst_cnt;
    logic [5:0]        fetch, instr_q;
    logic [STEP_W-1:0] step_inc;
    logic              idle_like, limit_hit;
    assign idle_like = state == IDLE || state == DONE;
    assign step_inc  = &bus.step_count ? bus.step_count : bus.step_count + 1'b1;
    assign limit_hit = bus.max_steps != '0 && step_inc == bus.max_steps;
    hidden_cpu_prog_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (bus.prog_we),
        .en    (idle_like),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (bus.cpu_out[ADDR_W-1:0]),
        .rdata (fetch)
    );
    // SETUP shows the fetched word straight away; PULSE replays the copy latched
    // in SETUP so the instruction cannot move if the PC changes on the CPU edge.
    always_comb begin
        state_n = state;
        bus.busy = !idle_like;
        bus.cpu_in = '0;
        bus.cpu_in[CPU_CLK] = state == RST_HI || state == PULSE;
        bus.cpu_in[CPU_RST] = state == RST_LO || state == RST_HI;
        bus.cpu_in[7:INSTR_LSB] = state == SETUP ? fetch : state == PULSE ? instr_q : 6'd0;
        case (state)
            IDLE, DONE: state_n = bus.start ? RST_LO : state;
            RST_LO:     state_n = bus.stop ? DONE : RST_HI;
            RST_HI:     state_n = bus.stop ? DONE : rst_cnt == RC_W'(RST_PULSES - 1) ? SETUP : RST_LO;
            SETUP:      state_n = bus.stop ? DONE : PULSE;
            PULSE:      state_n = bus.stop || limit_hit ? DONE : SETUP;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            rst_cnt        <= '0;
            instr_q        <= '0;
            bus.done       <= 1'b0;
            bus.step_count <= '0;
            bus.last_out   <= '0;
        end else begin
            state    <= state_n;
            bus.done <= state != DONE && state_n == DONE;
            if (idle_like && bus.start) begin
                rst_cnt        <= '0;
                bus.step_count <= '0;
            end
            if (state == RST_HI) rst_cnt <= rst_cnt + 1'b1;
            if (state == SETUP) instr_q <= fetch;
            // cpu_out has had the whole high phase to settle after the CPU edge
            if (state == PULSE) begin
                bus.step_count <= step_inc;
                bus.last_out   <= bus.cpu_out;
            end
        end
endmodule

// File: tb/tb_hidden_cpu_driver.sv
// tb_hidden_cpu_driver: scoreboard bench for hidden_cpu_driver with a stub CPU whose PC counts or follows a jump list
module tb_hidden_cpu_driver;
    import hidden_cpu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    hidden_cpu_driver_if #(.ADDR_W(4), .STEP_W(16)) bus ();
    hidden_cpu_driver #(.ADDR_W(4), .RST_PULSES(2), .STEP_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    int n_chk = 0;
    int n_fail = 0;
    logic [5:0] model_ram [16];
    logic [5:0] exp_q [$];
    logic [5:0] exp_e;
    bit sb_on = 1'b0;
    logic [7:0] pc = 8'h00;
    logic [7:0] jump_q [$];
    int edges = 0;
    assign bus.cpu_out = pc;
    always @(posedge bus.cpu_in[0]) begin
        if (bus.cpu_in[1]) pc <= 8'h00;
        else begin
            edges <= edges + 1;
            if (jump_q.size() > 0) pc <= jump_q.pop_front();
            else pc <= pc + 8'd1;
        end
    end
    always @(negedge clk)
        if (sb_on && rst_n && bus.cpu_in[0] && !bus.cpu_in[1]) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_pulse: instr %h, no expected entry", bus.cpu_in[7:2]);
            end else begin
                exp_e = exp_q.pop_front();
                if (bus.cpu_in[7:2] !== exp_e) begin
                    n_fail++;
                    $display("FAIL sb_instr: got %h expected %h", bus.cpu_in[7:2], exp_e);
                end
            end
        end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    function automatic bit in_pulse();
        return bus.cpu_in[0] && !bus.cpu_in[1];
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        bus.prog_we = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        cyc();
        bus.prog_we = 1'b0;
    endtask
    task automatic go(input logic [15:0] ms);
        bus.max_steps = ms;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask
    task automatic stop_now();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
    endtask
    task automatic wait_pulse(input string tag);
        for (int i = 0; i < 40 && !in_pulse(); i++) cyc();
        n_chk++;
        if (!in_pulse()) begin
            n_fail++;
            $display("FAIL %s: no cpu_clk pulse within 40 cycles, cpu_in %h", tag, bus.cpu_in);
        end
    endtask
    task automatic wait_done();
        for (int i = 0; i < 80 && !bus.done; i++) cyc();
    endtask
    task automatic count_reset_phases(output int highs, output int wide);
        bit prev;
        prev = 1'b0;
        highs = 0;
        wide = 0;
        for (int i = 0; i < 20 && bus.cpu_in[1]; i++) begin
            if (bus.cpu_in[0]) highs++;
            if (prev && bus.cpu_in[0]) wide++;
            prev = bus.cpu_in[0];
            cyc();
        end
    endtask
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bus.cpu_in !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_in: got %h expected 00", bus.cpu_in); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_chk++; if (bus.step_count !== 16'd0) begin n_fail++; $display("FAIL reset_step_count: got %0d expected 0", bus.step_count); end
        n_chk++; if (bus.last_out !== 8'h00) begin n_fail++; $display("FAIL reset_last_out: got %h expected 00", bus.last_out); end
        rst_n = 1'b1;
        cyc();
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b expected 0", bus.busy); end
    endtask
    task automatic test_load();
        int pulses;
        model_ram[0] = 6'h15;
        model_ram[1] = 6'h2A;
        model_ram[2] = 6'h3F;
        model_ram[3] = 6'h00;
        for (int i = 4; i < 16; i++) model_ram[i] = 6'(i * 7 + 3);
        model_ram[9] = mk_instr(OP_2, 2'd3, 2'd1);
        for (int i = 0; i < 16; i++) wr(4'(i), model_ram[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(model_ram[i]);
        sb_on = 1'b1;
        go(16'd0);
        for (int i = 0; i < 20 && !(bus.busy && !bus.cpu_in[1]); i++) cyc();
        n_chk++; if (bus.cpu_in[7:2] !== 6'h15 || bus.cpu_in[1:0] !== 2'b00) begin n_fail++; $display("FAIL load_first_setup: cpu_in %h expected 54", bus.cpu_in); end
        pulses = 0;
        for (int i = 0; i < 40 && pulses < 4; i++) begin
            cyc();
            if (in_pulse()) pulses++;
        end
        stop_now();
        n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b expected 1", bus.done); end
        n_chk++; if (bus.step_count !== 16'd4) begin n_fail++; $display("FAIL load_step_count: got %0d expected 4", bus.step_count); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL load_sb_drain: %0d entries left expected 0", exp_q.size()); end
        sb_on = 1'b0;
    endtask
    task automatic test_reset_seq();
        int highs, wide;
        bit low_ok;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_beats_stop: busy %b expected 1", bus.busy); end
        count_reset_phases(highs, wide);
        n_chk++; if (highs != 2) begin n_fail++; $display("FAIL rst_high_phases: got %0d expected 2", highs); end
        n_chk++; if (wide != 0) begin n_fail++; $display("FAIL rst_phase_width: got %0d wide phases expected 0", wide); end
        n_chk++; if (bus.cpu_in[1:0] !== 2'b00 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_first_setup: cpu_in %h busy %b expected rst/clk 0 busy 1", bus.cpu_in, bus.busy); end
        low_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (bus.cpu_in[1] !== 1'b0) low_ok = 1'b0;
        end
        n_chk++; if (!low_ok) begin n_fail++; $display("FAIL rst_released: cpu_rst seen 1 after SETUP expected 0"); end
        stop_now();
        n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rst_seq_stop: done %b expected 1", bus.done); end
    endtask
    task automatic test_step_limit();
        int e0;
        for (int i = 0; i < 5; i++) exp_q.push_back(model_ram[i]);
        sb_on = 1'b1;
        e0 = edges;
        go(16'd5);
        wait_done();
        n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL limit_done: got %b expected 1", bus.done); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL limit_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.step_count !== 16'd5) begin n_fail++; $display("FAIL limit_step_count: got %0d expected 5", bus.step_count); end
        n_chk++; if (bus.last_out !== 8'h05) begin n_fail++; $display("FAIL limit_last_out: got %h expected 05", bus.last_out); end
        n_chk++; if (edges - e0 != 5) begin n_fail++; $display("FAIL limit_edges: got %0d expected 5", edges - e0); end
        cyc();
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL limit_done_width: got %b expected 0", bus.done); end
        n_chk++; if (bus.cpu_in !== 8'h00) begin n_fail++; $display("FAIL limit_hold: cpu_in %h expected 00", bus.cpu_in); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL limit_sb_drain: %0d entries left expected 0", exp_q.size()); end
        sb_on = 1'b0;
    endtask
    task automatic test_fetch();
        model_ram[3] = mk_instr(OP_3, 2'd1, 2'd2);
        wr(4'd3, model_ram[3]);
        exp_q.push_back(model_ram[0]);
        exp_q.push_back(model_ram[9]);
        exp_q.push_back(model_ram[3]);
        jump_q.push_back(8'h09);
        jump_q.push_back(8'h13);
        sb_on = 1'b1;
        go(16'd3);
        wait_done();
        n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL fetch_done: got %b expected 1", bus.done); end
        n_chk++; if (bus.step_count !== 16'd3) begin n_fail++; $display("FAIL fetch_step_count: got %0d expected 3", bus.step_count); end
        n_chk++; if (bus.last_out !== 8'h14) begin n_fail++; $display("FAIL fetch_last_out: got %h expected 14", bus.last_out); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fetch_sb_drain: %0d entries left expected 0", exp_q.size()); end
        sb_on = 1'b0;
    endtask
    task automatic test_abort();
        exp_q.push_back(model_ram[0]);
        sb_on = 1'b1;
        go(16'd0);
        wait_pulse("abort_wait_pulse");
        wr(4'd0, ~model_ram[0]);
        n_chk++; if (bus.cpu_in[0] !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_in_setup: cpu_in %h busy %b expected clk 0 busy 1", bus.cpu_in, bus.busy); end
        stop_now();
        n_chk++; if (bus.cpu_in !== 8'h00) begin n_fail++; $display("FAIL abort_setup_cpu_in: got %h expected 00", bus.cpu_in); end
        n_chk++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_setup_done: done %b busy %b expected 1 0", bus.done, bus.busy); end
        n_chk++; if (bus.step_count !== 16'd1) begin n_fail++; $display("FAIL abort_setup_count: got %0d expected 1", bus.step_count); end
        exp_q.push_back(model_ram[0]);
        go(16'd0);
        wait_pulse("abort_wait_pulse2");
        stop_now();
        n_chk++; if (bus.step_count !== 16'd1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d expected 1", bus.step_count); end
        n_chk++; if (bus.cpu_in !== 8'h00 || bus.done !== 1'b1) begin n_fail++; $display("FAIL abort_pulse_fall: cpu_in %h done %b expected 00 1", bus.cpu_in, bus.done); end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_sb_drain: %0d entries left expected 0", exp_q.size()); end
        sb_on = 1'b0;
    endtask
    task automatic test_async_reset();
        int highs, wide, e0;
        go(16'd0);
        wait_pulse("async_wait_pulse");
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (bus.cpu_in !== 8'h00) begin n_fail++; $display("FAIL async_cpu_in: got %h expected 00", bus.cpu_in); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL async_done: got %b expected 0", bus.done); end
        #2 rst_n = 1'b1;
        e0 = edges;
        cyc();
        cyc();
        n_chk++; if (bus.busy !== 1'b0 || edges != e0) begin n_fail++; $display("FAIL async_idle: busy %b edges %0d expected 0 and 0", bus.busy, edges - e0); end
        go(16'd0);
        count_reset_phases(highs, wide);
        n_chk++; if (highs != 2 || wide != 0) begin n_fail++; $display("FAIL async_rerun_reset: highs %0d wide %0d expected 2 0", highs, wide); end
        stop_now();
        n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL async_rerun_stop: done %b expected 1", bus.done); end
    endtask
    initial begin
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.max_steps = '0;
        test_reset();
        test_load();
        test_reset_seq();
        test_step_limit();
        test_fetch();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
